// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative RV32M/RV64M multiply/divide unit.
// One operand bit per cycle behind a start/busy/done handshake.
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN:0]     hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   dv_q, dv_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, min_val, ones;

    logic [XLEN:0]     mul_sum, div_sh, div_diff, hi_n;
    logic [XLEN-1:0]   lo_n, quo, rmd, fin;
    logic [2*XLEN-1:0] prod;

    // Operand signedness, magnitudes and early-finish detection at start
    always_comb begin
        a_sgn    = (op == 3'b001) || (op == 3'b010) ||
                   (op == 3'b100) || (op == 3'b110);
        b_sgn    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa       = a_sgn & a[XLEN-1];
        sb       = b_sgn & b[XLEN-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        min_val  = {1'b1, {(XLEN-1){1'b0}}};
        ones     = '1;
        div_zero = op[2] && (b == '0);
        div_ovf  = ((op == 3'b100) || (op == 3'b110)) &&
                   (a == min_val) && (b == ones);
    end

    // One shift-add or restore-subtract step on {hi, lo}
    always_comb begin
        mul_sum  = hi_q + {1'b0, {XLEN{lo_q[0]}} & dv_q};
        div_sh   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, dv_q};
        if (op_q[2]) begin
            if (div_diff[XLEN]) begin
                hi_n = div_sh;
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_n = div_diff;
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_n = {1'b0, mul_sum[XLEN:1]};
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection after the final step
    always_comb begin
        prod = {hi_n[XLEN-1:0], lo_n};
        if (negq_q) prod = -prod;
        quo = negq_q ? -lo_n : lo_n;
        rmd = negr_q ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
        case (op_q)
            3'b000:                 fin = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin = quo;
            default:                fin = rmd;
        endcase
    end

    // Next-state and datapath load control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dv_d     = dv_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    negq_d = sa ^ sb;
                    negr_d = sa;
                    hi_d   = '0;
                    lo_d   = op[2] ? mag_a : mag_b;
                    dv_d   = op[2] ? mag_b : mag_a;
                    if (div_zero) begin
                        state_d  = DONE;
                        result_d = op[1] ? a : ones;
                    end else if (div_ovf) begin
                        state_d  = DONE;
                        result_d = op[1] ? '0 : a;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                hi_d  = hi_n;
                lo_d  = lo_n;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d  = DONE;
                    result_d = fin;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dv_q     <= dv_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed and random checks of mdu_iterative
// against an arithmetic reference model, XLEN=32 and XLEN=64.
module tb_mdu_iterative;
    logic        clk = 1'b0;
    logic        reset;
    logic        s32, s64;
    logic [2:0]  op32, op64;
    logic [31:0] a32, b32, r32;
    logic [63:0] a64, b64, r64;
    logic        busy32, done32, busy64, done64;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(32)) u32 (
        .clk(clk), .reset(reset), .start(s32), .op(op32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .result(r32)
    );

    mdu_iterative #(.XLEN(64)) u64 (
        .clk(clk), .reset(reset), .start(s64), .op(op64),
        .a(a64), .b(b64), .busy(busy64), .done(done64), .result(r64)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // RV32M semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref32(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = (ua * ub) >> 32;
            3'd4: begin
                if (b == 0) p = '1;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = ua;
                else p = sa / sb;
            end
            3'd5: p = (b == 0) ? '1 : ua / ub;
            3'd6: begin
                if (b == 0) p = ua;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = 0;
                else p = sa % sb;
            end
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int lat32(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 &&
            b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Issue one request from IDLE, scramble inputs, wait for done
    task automatic run(input bit w, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat,
                       output int nb);
        @(negedge clk);
        if (w) begin
            s64 = 1'b1; op64 = op; a64 = a; b64 = b;
        end else begin
            s32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
        end
        @(posedge clk);
        #1;
        s32 = 1'b0;
        s64 = 1'b0;
        op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
        op64 = 3'($urandom); a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
        lat = 1;
        nb = 0;
        while (lat < 200) begin
            if (w ? busy64 : busy32) nb++;
            if (w ? done64 : done32) break;
            @(posedge clk);
            #1;
            lat++;
        end
        res = w ? r64 : {32'b0, r32};
        @(posedge clk);
        #1;
    endtask

    task automatic dir32(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int elat);
        logic [63:0] res;
        int lat, nb;
        run(1'b0, op, 64'(a), 64'(b), res, lat, nb);
        check({tag, "_res"}, res, 64'(exp));
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_idle"}, 64'(busy32), 64'(0));
    endtask

    initial begin
        logic [63:0] res;
        int lat, nb, nd, first;
        logic [2:0] op;
        logic [31:0] ra, rb;

        reset = 1'b0;
        s32 = 1'b0; s64 = 1'b0;
        op32 = '0; a32 = '0; b32 = '0;
        op64 = '0; a64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy32), 64'(0));
        check("rst_done", 64'(done32), 64'(0));
        check("rst_res", 64'(r32), 64'(0));
        check("rst_res64", r64, 64'(0));
        reset = 1'b1;

        run(1'b0, 3'd0, 64'(7), 64'(32'hFFFFFFFD), res, lat, nb);
        check("mul_res", res, 64'(32'hFFFFFFEB));
        check("mul_lat", 64'(lat), 64'(33));
        check("mul_busy", 64'(nb), 64'(33));

        dir32("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        dir32("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        dir32("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        dir32("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        dir32("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        dir32("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        dir32("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        dir32("divu0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        dir32("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        dir32("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        dir32("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        // Extra starts during CALC and in the DONE cycle must be ignored
        @(negedge clk);
        s32 = 1'b1; op32 = 3'd0; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        #1;
        s32 = 1'b0;
        nd = 0;
        first = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 5 || c == 33) begin
                s32 = 1'b1; op32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
            end else begin
                s32 = 1'b0;
            end
            if (done32) begin
                nd++;
                if (first == 0) first = c;
            end
            if (c == 34) check("hs_busy_drop", 64'(busy32), 64'(0));
            @(posedge clk);
            #1;
        end
        s32 = 1'b0;
        check("hs_ndone", 64'(nd), 64'(1));
        check("hs_lat", 64'(first), 64'(33));
        check("hs_res", 64'(r32), 64'(12));
        check("hs_idle", 64'(busy32), 64'(0));

        // Reset in the middle of a divide
        @(negedge clk);
        s32 = 1'b1; op32 = 3'd5; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk);
        #1;
        s32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("mrst_busy", 64'(busy32), 64'(0));
        check("mrst_done", 64'(done32), 64'(0));
        check("mrst_res", 64'(r32), 64'(0));
        nd = 0;
        repeat (60) begin
            if (done32) nd++;
            @(posedge clk);
            #1;
        end
        check("mrst_nodone", 64'(nd), 64'(0));
        dir32("mrst_mul", 3'd0, 32'd2, 32'd3, 32'd6, 33);

        // Randomised operations against the reference model
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 200));
                default: ;
            endcase
            run(1'b0, op, 64'(ra), 64'(rb), res, lat, nb);
            check($sformatf("rnd%0d_op%0d_res", i, op), res,
                  64'(ref32(op, ra, rb)));
            check($sformatf("rnd%0d_op%0d_lat", i, op), 64'(lat),
                  64'(lat32(op, ra, rb)));
        end

        // 64-bit build
        run(1'b1, 3'd3, '1, '1, res, lat, nb);
        check("mulhu64_res", res, 64'hFFFFFFFFFFFFFFFE);
        check("mulhu64_lat", 64'(lat), 64'(65));
        run(1'b1, 3'd4, -64'sd9, 64'd4, res, lat, nb);
        check("div64_res", res, 64'hFFFFFFFFFFFFFFFE);
        check("div64_lat", 64'(lat), 64'(65));
        run(1'b1, 3'd7, 64'h123456789ABCDEF0, 64'd0, res, lat, nb);
        check("remu64_0_res", res, 64'h123456789ABCDEF0);
        check("remu64_0_lat", 64'(lat), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
